// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single Register_File write port: round-robin between
// ALU and load results, plus a per-register pending scoreboard that drives decode stall.
module regfile_wb_arbiter #(
   parameter int BITSIZE  = 64,
   parameter int REGSIZE  = 32,
   parameter int ZERO_REG = 31,
   localparam int SW      = $clog2(REGSIZE)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               alu_valid,
   output logic               alu_ready,
   input  logic [SW-1:0]      alu_sel,
   input  logic [BITSIZE-1:0] alu_data,
   input  logic               mem_valid,
   output logic               mem_ready,
   input  logic [SW-1:0]      mem_sel,
   input  logic [BITSIZE-1:0] mem_data,
   input  logic               issue_valid,
   input  logic [SW-1:0]      issue_sel,
   input  logic [SW-1:0]      rd_sel1,
   input  logic [SW-1:0]      rd_sel2,
   output logic               stall,
   output logic [SW-1:0]      WriteSelect,
   output logic [BITSIZE-1:0] WriteData,
   output logic               WriteEnable,
   output logic [REGSIZE-1:0] pending,
   output logic               wb_err
);

   localparam logic [SW-1:0] ZSEL = SW'(ZERO_REG);

   typedef enum logic {GRANT_ALU = 1'b0, GRANT_MEM = 1'b1} grant_t;

   // Handshake: a writeback transfers on the edge where valid && ready; a requester
   // whose valid is high and ready low must hold valid, sel and data unchanged.
   grant_t               last_grant;
   logic                 accept;
   logic [SW-1:0]        win_sel;
   logic [BITSIZE-1:0]   win_data;
   logic                 win_is_zero;
   logic [REGSIZE-1:0]   pend_nxt;

   // Ready depends only on the valids and the pointer, so there is no ready->ready loop.
   assign alu_ready   = alu_valid && (!mem_valid || (last_grant == GRANT_MEM));
   assign mem_ready   = mem_valid && (!alu_valid || (last_grant == GRANT_ALU));
   assign accept      = alu_ready || mem_ready;
   assign win_sel     = alu_ready ? alu_sel  : mem_sel;
   assign win_data    = alu_ready ? alu_data : mem_data;
   assign win_is_zero = (win_sel == ZSEL);

   // Clear for the retiring writer first, then the new issue, so a same-register set wins.
   always_comb begin
      pend_nxt = pending;
      if (accept) pend_nxt[win_sel] = 1'b0;
      if (issue_valid && (issue_sel != ZSEL)) pend_nxt[issue_sel] = 1'b1;
      pend_nxt[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant  <= GRANT_MEM;
         WriteEnable <= 1'b0;
         WriteSelect <= '0;
         WriteData   <= '0;
         pending     <= '0;
         wb_err      <= 1'b0;
      end else begin
         WriteEnable <= accept && !win_is_zero;
         pending     <= pend_nxt;
         if (accept) begin
            last_grant  <= alu_ready ? GRANT_ALU : GRANT_MEM;
            WriteSelect <= win_sel;
            WriteData   <= win_data;
            if (!win_is_zero && !pending[win_sel]) wb_err <= 1'b1;
         end
      end
   end

   // The WriteEnable term covers the cycle before Register_File has committed the value.
   function automatic logic hit(input logic [SW-1:0] s);
      return (s != ZSEL) && (pending[s] || (WriteEnable && (WriteSelect == s)));
   endfunction

   assign stall = hit(rd_sel1) || hit(rd_sel2);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes go into a queue and a
// negedge monitor pops them whenever WriteEnable is seen; other checks are inline.
module tb_regfile_wb_arbiter;

   localparam int BITSIZE = 64;
   localparam int REGSIZE = 32;
   localparam int SW      = 5;

   logic               clk = 1'b0;
   logic               rst;
   logic               alu_valid, mem_valid, issue_valid;
   logic               alu_ready, mem_ready;
   logic [SW-1:0]      alu_sel, mem_sel, issue_sel, rd_sel1, rd_sel2;
   logic [BITSIZE-1:0] alu_data, mem_data;
   logic               stall, WriteEnable, wb_err;
   logic [SW-1:0]      WriteSelect;
   logic [BITSIZE-1:0] WriteData;
   logic [REGSIZE-1:0] pending;

   logic [SW+BITSIZE-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   regfile_wb_arbiter #(.BITSIZE(BITSIZE), .REGSIZE(REGSIZE), .ZERO_REG(31)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_sel(alu_sel), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_sel(mem_sel), .mem_data(mem_data),
      .issue_valid(issue_valid), .issue_sel(issue_sel),
      .rd_sel1(rd_sel1), .rd_sel2(rd_sel2), .stall(stall),
      .WriteSelect(WriteSelect), .WriteData(WriteData), .WriteEnable(WriteEnable),
      .pending(pending), .wb_err(wb_err)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [SW-1:0] sel, input logic [BITSIZE-1:0] data);
      exp_q.push_back({sel, data});
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst === 1'b1 && WriteEnable === 1'b1) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL wb_unexpected: got sel %0d data %0h expected no write", WriteSelect, WriteData);
         end else begin
            logic [SW+BITSIZE-1:0] e;
            e = exp_q.pop_front();
            if ({WriteSelect, WriteData} !== e) begin
               n_err++;
               $display("FAIL wb_write: got sel %0d data %0h expected sel %0d data %0h",
                        WriteSelect, WriteData, e[SW+BITSIZE-1:BITSIZE], e[BITSIZE-1:0]);
            end
         end
      end
   end

   initial begin
      rst = 1'b0;
      {alu_valid, mem_valid, issue_valid} = '0;
      {alu_sel, mem_sel, issue_sel, rd_sel1, rd_sel2} = '0;
      alu_data = '0; mem_data = '0;
      repeat (3) step();
      chk("rst_we", 64'(WriteEnable), 64'd0);
      chk("rst_pending", 64'(pending), 64'd0);
      chk("rst_err", 64'(wb_err), 64'd0);
      chk("rst_wsel", 64'(WriteSelect), 64'd0);
      chk("rst_wdata", WriteData, 64'd0);
      rst = 1'b1;
      step();
      chk("idle_stall", 64'(stall), 64'd0);
      chk("idle_ready", 64'({alu_ready, mem_ready}), 64'd0);

      // round-robin conflict, ALU first after reset
      issue_valid = 1'b1; issue_sel = 5'd2; step();
      issue_sel = 5'd3; step();
      issue_valid = 1'b0;
      chk("rr_pending_pre", 64'(pending), 64'h0C);
      alu_valid = 1'b1; alu_sel = 5'd2; alu_data = 64'hA1;
      mem_valid = 1'b1; mem_sel = 5'd3; mem_data = 64'hB1;
      issue_valid = 1'b1; issue_sel = 5'd2; #1;
      chk("rr1_ready", 64'({alu_ready, mem_ready}), 64'b10);
      push(5'd2, 64'hA1); step();
      alu_data = 64'hA2; issue_sel = 5'd3; #1;
      chk("rr2_ready", 64'({alu_ready, mem_ready}), 64'b01);
      push(5'd3, 64'hB1); step();
      chk("rr_pending_mid", 64'(pending), 64'h0C);
      mem_data = 64'hB2; issue_valid = 1'b0; #1;
      chk("rr3_ready", 64'({alu_ready, mem_ready}), 64'b10);
      push(5'd2, 64'hA2); step();
      alu_valid = 1'b0; #1;
      chk("rr4_ready", 64'({alu_ready, mem_ready}), 64'b01);
      push(5'd3, 64'hB2); step();
      mem_valid = 1'b0;
      chk("rr_pending_post", 64'(pending), 64'h00);
      chk("rr_err", 64'(wb_err), 64'd0);

      // single write with stall through the WriteEnable cycle
      issue_valid = 1'b1; issue_sel = 5'd4; step();
      issue_valid = 1'b0;
      chk("sw_pending_set", 64'(pending), 64'h10);
      rd_sel1 = 5'd4; #1;
      chk("sw_stall_pend", 64'(stall), 64'd1);
      alu_valid = 1'b1; alu_sel = 5'd4; alu_data = 64'hF; #1;
      chk("sw_ready", 64'({alu_ready, mem_ready}), 64'b10);
      push(5'd4, 64'hF); step();
      alu_valid = 1'b0;
      chk("sw_pending_clr", 64'(pending), 64'h00);
      chk("sw_we", 64'(WriteEnable), 64'd1);
      #1 chk("sw_stall_we", 64'(stall), 64'd1);
      step();
      chk("sw_we_off", 64'(WriteEnable), 64'd0);
      #1 chk("sw_stall_off", 64'(stall), 64'd0);
      rd_sel1 = 5'd0;

      // zero register: accepted but never written or pending
      issue_valid = 1'b1; issue_sel = 5'd31;
      mem_valid = 1'b1; mem_sel = 5'd31; mem_data = 64'h1234; rd_sel2 = 5'd31; #1;
      chk("xzr_ready", 64'({alu_ready, mem_ready}), 64'b01);
      chk("xzr_stall", 64'(stall), 64'd0);
      step();
      issue_valid = 1'b0; mem_valid = 1'b0;
      chk("xzr_pending", 64'(pending), 64'h00);
      chk("xzr_we", 64'(WriteEnable), 64'd0);
      chk("xzr_err", 64'(wb_err), 64'd0);
      rd_sel2 = 5'd0;

      // same-register set and clear: set wins
      issue_valid = 1'b1; issue_sel = 5'd5; step();
      chk("sc_pending_pre", 64'(pending), 64'h20);
      alu_valid = 1'b1; alu_sel = 5'd5; alu_data = 64'h55;
      push(5'd5, 64'h55); step();
      chk("sc_pending_same", 64'(pending), 64'h20);
      chk("sc_we", 64'(WriteEnable), 64'd1);
      // different registers: both apply
      issue_sel = 5'd6; alu_data = 64'h56;
      push(5'd5, 64'h56); step();
      issue_valid = 1'b0; alu_valid = 1'b0;
      chk("sc_pending_diff", 64'(pending), 64'h40);
      chk("sc_err", 64'(wb_err), 64'd0);

      // write to a non-pending register sets the sticky error
      alu_valid = 1'b1; alu_sel = 5'd7; alu_data = 64'h77;
      push(5'd7, 64'h77); step();
      alu_valid = 1'b0;
      chk("err_set", 64'(wb_err), 64'd1);
      step(); step();
      chk("err_sticky", 64'(wb_err), 64'd1);

      // build pending=0x14, then reset with a transfer in flight
      alu_valid = 1'b1; alu_sel = 5'd6; alu_data = 64'h66;
      issue_valid = 1'b1; issue_sel = 5'd2;
      push(5'd6, 64'h66); step();
      alu_valid = 1'b0; issue_sel = 5'd4; step();
      issue_valid = 1'b0;
      chk("mr_pending_pre", 64'(pending), 64'h14);
      alu_valid = 1'b1; alu_sel = 5'd9; alu_data = 64'h99; #2;
      rst = 1'b0; #1;
      chk("mr_we", 64'(WriteEnable), 64'd0);
      chk("mr_pending", 64'(pending), 64'd0);
      chk("mr_err", 64'(wb_err), 64'd0);
      chk("mr_wsel", 64'(WriteSelect), 64'd0);
      chk("mr_wdata", WriteData, 64'd0);
      step();
      chk("mr_we_held", 64'(WriteEnable), 64'd0);
      chk("mr_data_held", WriteData, 64'd0);
      alu_valid = 1'b0;
      rst = 1'b1; step();

      // first conflict after reset grants ALU again
      alu_valid = 1'b1; alu_sel = 5'd10; alu_data = 64'hAA;
      mem_valid = 1'b1; mem_sel = 5'd11; mem_data = 64'hBB; #1;
      chk("post_rst_ready", 64'({alu_ready, mem_ready}), 64'b10);
      push(5'd10, 64'hAA); step();
      alu_valid = 1'b0; #1;
      chk("post_rst_mem", 64'({alu_ready, mem_ready}), 64'b01);
      push(5'd11, 64'hBB); step();
      mem_valid = 1'b0;
      repeat (3) step();
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish expected finish by 20000");
      $fatal(1);
   end

endmodule
